mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single external memory bus between two requesters: the data port (LoadStore) and the
//  instruction-prefetch port. Owns the bus for one transfer at a time, forwards address/data/strobes
//  of the owner and routes m_ack back to it only. A LOCK input holds data-port ownership across
//  transfers for locked read-modify-write sequences. Sits between the core and the memory bus.
// PARAMETERS
//  AW  19  address width; addresses are word addresses [AW:1]
//  DW  16  data width; bytesel width is DW/8
// PORTS
//  clk          in   1      clock
//  reset        in   1      asynchronous, active-high reset
//  d_m_addr     in   AW     data-port word address
//  d_m_data_out in   DW     data-port write data
//  d_m_access   in   1      data-port request; held until d_m_ack
//  d_m_wr_en    in   1      data-port write strobe
//  d_m_bytesel  in   DW/8   data-port byte lanes
//  d_lock       in   1      keep data-port ownership after each ack while high
//  d_m_ack      out  1      ack to data port
//  d_m_data_in  out  DW     read data to data port
//  i_m_addr     in   AW     prefetch word address (read-only, all lanes)
//  i_m_access   in   1      prefetch request; held until i_m_ack
//  i_m_ack      out  1      ack to prefetch port
//  i_m_data_in  out  DW     read data to prefetch port
//  q_m_addr     out  AW     bus address
//  q_m_data_out out  DW     bus write data
//  q_m_access   out  1      bus request
//  q_m_wr_en    out  1      bus write strobe
//  q_m_bytesel  out  DW/8   bus byte lanes
//  q_m_data_in  in   DW     bus read data
//  q_m_ack      in   1      bus ack, one-cycle pulse
//  q_owner      out  2      00 none, 01 data, 10 prefetch (debug and status)
// BEHAVIOUR
//  - FSM states: IDLE, GRANT_D, GRANT_I. Reset forces IDLE and clears last_owner. All q_* outputs are 0
//    in IDLE, and d_m_ack and i_m_ack are 0.
//  - IDLE: the grant decision is registered. If d_m_access is high, the next state is GRANT_D. Else, if
//    i_m_access is high, the next state is GRANT_I. If neither is high, stay in IDLE. A request
//    therefore sees q_m_access no earlier than 1 cycle after it is raised.
//  - GRANT_x: q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel, q_m_access are driven
//    combinationally from owner x. q_m_access equals x_m_access gated by the state.
//  - Prefetch port values driven in GRANT_I: wr_en=0, bytesel all-ones, data_out=0.
//  - Ack routing: x_m_ack = q_m_ack & (state==GRANT_x). The other port's ack stays 0.
//  - d_m_data_in and i_m_data_in both equal q_m_data_in. Only the acked port samples it.
//  - On q_m_ack in GRANT_D with d_lock=1: stay in GRANT_D. Otherwise, on any q_m_ack, go to IDLE and
//    set last_owner to x. This gives one dead cycle between unlocked transfers.
//  - In GRANT_D, the data port may drop d_m_access for several cycles between locked transfers; the
//    state is held while d_lock=1.
//  - Withdrawal: in GRANT_x with x_m_access=0, no ack, and (x==I or d_lock=0), go to IDLE next cycle.
//    No ack is generated.
//  - A q_m_ack arriving in IDLE is ignored; no port is acked.
//  - d_lock falling while in GRANT_D with no transfer pending: go to IDLE next cycle.
//  - Reset mid-transfer: q_m_access drops immediately (asynchronous reset) and the in-flight
//    transfer is abandoned.
//  - q_owner is registered from the state encoding.
// CONFIGURATION
//  MEM_BUS_ARB_ROUND_ROBIN_EN
//   - Undefined: fixed priority in IDLE, data port over prefetch. The prefetch port may starve
//     while the data port requests back-to-back.
//   - Defined: when both ports request in IDLE, grant the port that is not last_owner. A single
//     requester is always granted. The d_lock hold still takes precedence.
// TESTING
//  - Single data read: d_m_access=1 at cycle 0 with addr 19'h00123, memory acks after 2 cycles
//    -> q_m_access at cycle 1, d_m_ack pulses with data 16'hBEEF, i_m_ack stays 0, state returns
//    to IDLE.
//  - Simultaneous requests, macro off -> data port is served first. Prefetch is granted 1 cycle
//    after d_m_ack, with q_m_bytesel=2'b11 and q_m_wr_en=0.
//  - Simultaneous continuous requests, macro on -> grants alternate D,I,D,I across 4 acks, with
//    q_owner values 01,10,01,10.
//  - Locked RMW: d_lock=1, read ack, then a write 3 cycles later, with i_m_access=1 throughout ->
//    no GRANT_I until d_lock=0. The write carries q_m_wr_en=1 and d_m_data_out.
//  - Unaligned word pair: d_m_access re-raised the cycle after the first ack -> second grant 1
//    cycle later with the address incremented. Total: 2 acks, no prefetch ack.
//  - Reset asserted during GRANT_I before the ack -> q_m_access=0 immediately and q_owner=00.
//    After release, a pending i_m_access is regranted 1 cycle later.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between data and prefetch ports, with data-port lock; MEM_BUS_ARB_ROUND_ROBIN_EN selects round-robin over fixed data priority
module mem_bus_arbiter #(
  parameter int AW = 19,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   d_m_addr,
  input  logic [DW-1:0]   d_m_data_out,
  input  logic            d_m_access,
  input  logic            d_m_wr_en,
  input  logic [DW/8-1:0] d_m_bytesel,
  input  logic            d_lock,
  output logic            d_m_ack,
  output logic [DW-1:0]   d_m_data_in,
  input  logic [AW-1:0]   i_m_addr,
  input  logic            i_m_access,
  output logic            i_m_ack,
  output logic [DW-1:0]   i_m_data_in,
  output logic [AW-1:0]   q_m_addr,
  output logic [DW-1:0]   q_m_data_out,
  output logic            q_m_access,
  output logic            q_m_wr_en,
  output logic [DW/8-1:0] q_m_bytesel,
  input  logic [DW-1:0]   q_m_data_in,
  input  logic            q_m_ack,
  output logic [1:0]      q_owner
);
  typedef enum logic [1:0] {IDLE = 2'b00, GRANT_D = 2'b01, GRANT_I = 2'b10} state_t;
  state_t state, state_next;
  logic pick_i;
  logic own_d, own_i;
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
  logic last_d;
  // remember whether the data port owned the last completed transfer
  always_ff @(posedge clk or posedge reset)
    if (reset) last_d <= 1'b0;
    else if (q_m_ack && state == GRANT_D && !d_lock) last_d <= 1'b1;
    else if (q_m_ack && state == GRANT_I) last_d <= 1'b0;
  assign pick_i = (d_m_access && i_m_access) ? last_d : !d_m_access;
`else
  assign pick_i = !d_m_access;
`endif
  // grant decision and release rules; lock pins the data port across transfers
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = (d_m_access || i_m_access) ? (pick_i ? GRANT_I : GRANT_D) : IDLE;
      GRANT_D: state_next = ((q_m_ack || !d_m_access) && !d_lock) ? IDLE : GRANT_D;
      GRANT_I: state_next = (q_m_ack || !i_m_access) ? IDLE : GRANT_I;
      default: state_next = IDLE;
    endcase
  end
  // state register; q_owner mirrors the state encoding
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      q_owner <= 2'b00;
    end else begin
      state   <= state_next;
      q_owner <= state_next;
    end
  assign own_d = (state == GRANT_D);
  assign own_i = (state == GRANT_I);
  // forward the owner's request onto the bus; prefetch is a full-width read
  always_comb begin
    q_m_access   = own_d ? d_m_access : (own_i & i_m_access);
    q_m_addr     = own_d ? d_m_addr : own_i ? i_m_addr : '0;
    q_m_data_out = own_d ? d_m_data_out : '0;
    q_m_wr_en    = own_d & d_m_wr_en;
    q_m_bytesel  = own_d ? d_m_bytesel : {(DW/8){own_i}};
    d_m_ack      = q_m_ack & own_d;
    i_m_ack      = q_m_ack & own_i;
    d_m_data_in  = q_m_data_in;
    i_m_data_in  = q_m_data_in;
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and random checks of mem_bus_arbiter against an ownership model
module tb_mem_bus_arbiter;
  localparam int AW = 19;
  localparam int DW = 16;
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [AW-1:0] d_m_addr = '0, i_m_addr = '0, q_m_addr;
  logic [DW-1:0] d_m_data_out = '0, q_m_data_in = '0, d_m_data_in, i_m_data_in, q_m_data_out;
  logic d_m_access = 1'b0, d_m_wr_en = 1'b0, d_lock = 1'b0, i_m_access = 1'b0, q_m_ack = 1'b0;
  logic [1:0] d_m_bytesel = 2'b11, q_m_bytesel, q_owner;
  logic d_m_ack, i_m_ack, q_m_access, q_m_wr_en;

  mem_bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .d_m_addr(d_m_addr), .d_m_data_out(d_m_data_out), .d_m_access(d_m_access),
    .d_m_wr_en(d_m_wr_en), .d_m_bytesel(d_m_bytesel), .d_lock(d_lock),
    .d_m_ack(d_m_ack), .d_m_data_in(d_m_data_in),
    .i_m_addr(i_m_addr), .i_m_access(i_m_access), .i_m_ack(i_m_ack), .i_m_data_in(i_m_data_in),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_access(q_m_access),
    .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel), .q_m_data_in(q_m_data_in),
    .q_m_ack(q_m_ack), .q_owner(q_owner)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int m_own = 0, m_last = 0;
  int mem_cnt = 0, mem_lat = 2;
  bit rand_lat = 1'b0;
  bit d_done = 1'b0, i_done = 1'b0;
  int acks[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a == 19'h00123) ? 16'hBEEF : (a[15:0] ^ 16'hA5A5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ownership model: who holds the bus after this edge (0 none, 1 data, 2 prefetch)
  task automatic model_edge();
    int nxt;
    if (reset) begin
      m_own = 0;
      m_last = 0;
      return;
    end
    nxt = m_own;
    if (m_own == 0) begin
      if (d_m_access && i_m_access) nxt = (RR && m_last == 1) ? 2 : 1;
      else if (d_m_access) nxt = 1;
      else if (i_m_access) nxt = 2;
    end else if (m_own == 1) begin
      if (q_m_ack && !d_lock) begin nxt = 0; m_last = 1; end
      else if (!q_m_ack && !d_m_access && !d_lock) nxt = 0;
    end else begin
      if (q_m_ack) m_last = 2;
      if (q_m_ack || !i_m_access) nxt = 0;
    end
    m_own = nxt;
  endtask

  // memory: acks after mem_lat cycles of continuous request, one-cycle pulse
  task automatic mem_drive();
    if (q_m_ack) begin
      q_m_ack = 1'b0;
      mem_cnt = 0;
    end else if (q_m_access) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        q_m_ack = 1'b1;
        q_m_data_in = mem_word(q_m_addr);
        mem_cnt = 0;
        if (rand_lat) mem_lat = $urandom_range(1, 3);
      end
    end else mem_cnt = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_edge();
    mem_drive();
  endtask

  // requesters: mode 0 drop after ack, 1 random traffic, 2 keep requesting
  task automatic master(input int mode);
    if (d_done && mode != 2) d_m_access = 1'b0;
    if (i_done && mode != 2) i_m_access = 1'b0;
    if (mode == 1) begin
      if (!d_m_access && $urandom_range(0, 2) == 0) begin
        d_m_access = 1'b1;
        d_m_addr = AW'($urandom);
        d_m_data_out = DW'($urandom);
        d_m_wr_en = 1'($urandom);
        d_m_bytesel = 2'($urandom);
      end
      if (!i_m_access && $urandom_range(0, 2) == 0) begin
        i_m_access = 1'b1;
        i_m_addr = AW'($urandom);
      end
      if ($urandom_range(0, 7) == 0) d_lock = ~d_lock;
    end
  endtask

  task automatic fin();
    logic ea, ew, eda, eia;
    logic [AW-1:0] eadr;
    logic [DW-1:0] edo;
    logic [1:0] ebs;
    #1;
    ea   = (m_own == 1) ? d_m_access : (m_own == 2) ? i_m_access : 1'b0;
    eadr = (m_own == 1) ? d_m_addr : (m_own == 2) ? i_m_addr : '0;
    edo  = (m_own == 1) ? d_m_data_out : '0;
    ew   = (m_own == 1) ? d_m_wr_en : 1'b0;
    ebs  = (m_own == 1) ? d_m_bytesel : (m_own == 2) ? 2'b11 : 2'b00;
    eda  = q_m_ack && m_own == 1;
    eia  = q_m_ack && m_own == 2;
    chk("q_owner", 32'(q_owner), 32'(m_own));
    chk("q_m_access", 32'(q_m_access), 32'(ea));
    chk("q_m_addr", 32'(q_m_addr), 32'(eadr));
    chk("q_m_data_out", 32'(q_m_data_out), 32'(edo));
    chk("q_m_wr_en", 32'(q_m_wr_en), 32'(ew));
    chk("q_m_bytesel", 32'(q_m_bytesel), 32'(ebs));
    chk("d_m_ack", 32'(d_m_ack), 32'(eda));
    chk("i_m_ack", 32'(i_m_ack), 32'(eia));
    if (eda) chk("d_m_data_in", 32'(d_m_data_in), 32'(mem_word(d_m_addr)));
    if (eia) chk("i_m_data_in", 32'(i_m_data_in), 32'(mem_word(i_m_addr)));
    d_done = eda;
    i_done = eia;
    if (eda) acks.push_back(1);
    if (eia) acks.push_back(2);
  endtask

  task automatic run(input int n, input int mode);
    repeat (n) begin cyc(); master(mode); fin(); end
  endtask

  task automatic wait_acks(input int target, input int mode, input int budget);
    int k = 0;
    while (acks.size() < target && k < budget) begin cyc(); master(mode); fin(); k++; end
    chk("ack_budget", 32'(acks.size() >= target), 32'd1);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((d_m_access || i_m_access) && k < budget) begin cyc(); master(0); fin(); k++; end
    chk("drain", 32'(d_m_access | i_m_access), 32'd0);
  endtask

  initial begin
    int base;
    run(1, 0);
    chk("reset_owner", 32'(q_owner), 32'd0);
    reset = 1'b0;
    // single data read with two-cycle memory latency
    d_m_addr = 19'h00123;
    d_m_access = 1'b1;
    fin();
    chk("t1_no_early_grant", 32'(q_m_access), 32'd0);
    run(1, 0);
    chk("t1_grant", 32'(q_m_access), 32'd1);
    run(1, 0);
    chk("t1_d_ack", 32'(d_m_ack), 32'd1);
    chk("t1_data", 32'(d_m_data_in), 32'h0000BEEF);
    chk("t1_i_ack", 32'(i_m_ack), 32'd0);
    run(1, 0);
    chk("t1_idle", 32'(q_owner), 32'd0);
    // simultaneous requests
    base = acks.size();
    d_m_addr = 19'h00200;
    i_m_addr = 19'h00300;
    d_m_access = 1'b1;
    i_m_access = 1'b1;
    wait_acks(base + 2, 0, 40);
    chk("sim_first", 32'(acks[base]), RR ? 32'd2 : 32'd1);
    chk("sim_second", 32'(acks[base+1]), RR ? 32'd1 : 32'd2);
    // bus ack while idle is ignored
    q_m_ack = 1'b1;
    fin();
    chk("idle_ack_d", 32'(d_m_ack), 32'd0);
    run(1, 0);
    // locked read-modify-write with prefetch pending
    base = acks.size();
    d_m_addr = 19'h00400;
    d_m_wr_en = 1'b0;
    d_lock = 1'b1;
    d_m_access = 1'b1;
    run(1, 0);
    i_m_addr = 19'h00500;
    i_m_access = 1'b1;
    wait_acks(base + 1, 0, 20);
    run(3, 0);
    chk("lock_gap_owner", 32'(q_owner), 32'd1);
    d_m_wr_en = 1'b1;
    d_m_data_out = 16'hC0DE;
    d_m_access = 1'b1;
    run(1, 0);
    chk("lock_wr_en", 32'(q_m_wr_en), 32'd1);
    chk("lock_wr_data", 32'(q_m_data_out), 32'h0000C0DE);
    wait_acks(base + 2, 0, 20);
    run(2, 0);
    chk("lock_held", 32'(q_owner), 32'd1);
    chk("lock_rd_ack", 32'(acks[base]), 32'd1);
    chk("lock_wr_ack", 32'(acks[base+1]), 32'd1);
    d_lock = 1'b0;
    d_m_wr_en = 1'b0;
    wait_acks(base + 3, 0, 20);
    chk("lock_then_i", 32'(acks[base+2]), 32'd2);
    // continuous requests from both ports
    base = acks.size();
    d_m_access = 1'b1;
    i_m_access = 1'b1;
    wait_acks(base + 4, 2, 60);
    for (int k = 0; k < 4; k++)
      chk("alternate", 32'(acks[base+k]), (RR && k % 2 == 1) ? 32'd2 : 32'd1);
    drain(60);
    // word pair with address increment
    base = acks.size();
    d_m_addr = 19'h0FFFF;
    d_m_access = 1'b1;
    wait_acks(base + 1, 2, 20);
    d_m_addr = d_m_addr + 19'd1;
    wait_acks(base + 2, 2, 20);
    run(2, 0);
    chk("pair_count", 32'(acks.size()), 32'(base + 2));
    chk("pair_second", 32'(acks[base+1]), 32'd1);
    // prefetch withdrawal
    mem_lat = 8;
    i_m_addr = 19'h00777;
    i_m_access = 1'b1;
    run(2, 0);
    chk("wd_granted", 32'(q_owner), 32'd2);
    i_m_access = 1'b0;
    run(1, 0);
    chk("wd_idle", 32'(q_owner), 32'd0);
    // reset in the middle of a prefetch transfer
    mem_lat = 6;
    i_m_addr = 19'h0002A;
    i_m_access = 1'b1;
    run(2, 0);
    chk("rst_pre_owner", 32'(q_owner), 32'd2);
    reset = 1'b1;
    #1;
    chk("rst_access", 32'(q_m_access), 32'd0);
    chk("rst_owner", 32'(q_owner), 32'd0);
    m_own = 0;
    m_last = 0;
    mem_cnt = 0;
    run(1, 0);
    reset = 1'b0;
    run(1, 0);
    chk("rst_regrant", 32'(q_owner), 32'd2);
    mem_lat = 2;
    base = acks.size();
    wait_acks(base + 1, 0, 20);
    run(1, 0);
    // random traffic
    rand_lat = 1'b1;
    run(600, 1);
    d_lock = 1'b0;
    drain(200);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
